// File: rtl/mux_nway_reg.sv
// Registered N-input word mux with per-channel valid/ready, explicit-select or round-robin grant.
// Latency: one cycle from input handshake to out_valid; sustains one word per cycle.
// Backpressure: while out_valid && !out_ready every output and the rr pointer hold and no in_ready is raised.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_data/in_valid  flattened channel words (channel i at [i*WORD_LENGTH +: WORD_LENGTH]) and valids
//   in_ready          one-hot (or zero) combinational accept toward the granted channel
//   sel, arb_mode     channel index for mode 0; arb_mode 1 selects round-robin
//   out_data/out_valid/out_ready/out_sel  registered output stage and index of its source
module mux_nway_reg #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_INPUTS  = 4,
  localparam int SEL_W = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS*WORD_LENGTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]           in_valid,
  output logic [NUM_INPUTS-1:0]           in_ready,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            arb_mode,
  output logic [WORD_LENGTH-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SEL_W-1:0]                out_sel
);

  // One extra bit so ptr + offset can exceed NUM_INPUTS before wrapping.
  localparam logic [SEL_W:0] NUM_W = (SEL_W+1)'(NUM_INPUTS);

  logic [SEL_W-1:0]       ptr;
  logic [SEL_W-1:0]       ptr_nxt;
  logic [SEL_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic [WORD_LENGTH-1:0] grant_dat;
  logic [SEL_W:0]         scan_idx;
  logic                   can_load;
  logic                   load;

  assign can_load = !out_valid || out_ready;
  assign load     = can_load && grant_vld;

  // Grant selection. In round-robin mode the offsets are scanned from the
  // farthest to the nearest, so the last hit (nearest to ptr) wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!arb_mode) begin
      grant_idx = sel;
      // An out-of-range select never grants anything.
      if ({1'b0, sel} < NUM_W) begin
        grant_vld = in_valid[sel];
      end
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        scan_idx = {1'b0, ptr} + (SEL_W+1)'(k);
        if (scan_idx >= NUM_W) begin
          scan_idx = scan_idx - NUM_W;
        end
        if (in_valid[scan_idx[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx[SEL_W-1:0];
        end
      end
    end
  end

  // Data path only ever looks at the granted channel, so idle channels
  // carrying X cannot leak into out_data.
  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_dat = in_data[i*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = rst && load && (grant_idx == SEL_W'(i));
    end
  end

  assign ptr_nxt = ({1'b0, grant_idx} == NUM_W - 1'b1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (can_load) begin
      out_valid <= grant_vld;
      // With no grant the last word and index stay put; only valid drops.
      if (grant_vld) begin
        out_data <= grant_dat;
        out_sel  <= grant_idx;
        ptr      <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mux_nway_reg.sv
// Bench for mux_nway_reg: a 4-channel instance checked every cycle against a
// behavioural model, plus a 3-channel instance for non-power-of-two wrap.
module tb_mux_nway_reg;

  logic         clk;
  logic         rst;

  logic [127:0] in_data4;
  logic [3:0]   in_valid4;
  logic [3:0]   in_ready4;
  logic [1:0]   sel4;
  logic         arb_mode4;
  logic [31:0]  out_data4;
  logic         out_valid4;
  logic         out_ready4;
  logic [1:0]   out_sel4;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic         arb_mode3;
  logic [31:0]  out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic [1:0]   out_sel3;

  int vectors;
  int miscompares;

  // Reference model state for the 4-channel instance.
  bit          m_vld;
  logic [31:0] m_dat;
  int          m_sel;
  int          m_ptr;

  mux_nway_reg #(.WORD_LENGTH(32), .NUM_INPUTS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sel(sel4), .arb_mode(arb_mode4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sel(out_sel4)
  );

  mux_nway_reg #(.WORD_LENGTH(32), .NUM_INPUTS(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .arb_mode(arb_mode3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sel(out_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word4(input int idx);
    return in_data4[idx*32 +: 32];
  endfunction

  // Grant per the rules: explicit select, or first valid channel at or after ptr.
  function automatic void model_grant(output bit gv, output int gi);
    int j;
    gv = 0;
    gi = 0;
    if (!arb_mode4) begin
      gi = int'(sel4);
      gv = in_valid4[sel4];
    end else begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (!gv && in_valid4[j]) begin
          gv = 1;
          gi = j;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_vld = 0;
    m_dat = '0;
    m_sel = 0;
    m_ptr = 0;
  endfunction

  // Settle the combinational path and check in_ready against the model.
  task automatic pre();
    bit gv;
    int gi;
    logic [3:0] e;
    #1;
    model_grant(gv, gi);
    e = '0;
    if (rst && (!m_vld || out_ready4) && gv) e[gi] = 1'b1;
    check("in_ready", 32'(in_ready4), 32'(e));
  endtask

  // Advance one clock and check the registered outputs against the model.
  task automatic step_edge();
    bit gv;
    int gi;
    bit n_vld;
    logic [31:0] n_dat;
    int n_sel, n_ptr;
    model_grant(gv, gi);
    n_vld = m_vld; n_dat = m_dat; n_sel = m_sel; n_ptr = m_ptr;
    if (rst && (!m_vld || out_ready4)) begin
      n_vld = gv;
      if (gv) begin
        n_dat = word4(gi);
        n_sel = gi;
        n_ptr = (gi + 1) % 4;
      end
    end
    @(posedge clk);
    m_vld = n_vld; m_dat = n_dat; m_sel = n_sel; m_ptr = n_ptr;
    #1;
    check("out_valid", 32'(out_valid4), 32'(m_vld));
    check("out_data", out_data4, m_dat);
    check("out_sel", 32'(out_sel4), 32'(m_sel));
  endtask

  initial begin
    int exp_seq[6];
    int exp3[4];
    vectors     = 0;
    miscompares = 0;
    model_reset();

    in_data4   = {32'hD0D0_0003, 32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    in_valid4  = 4'b1111;
    sel4       = 2'd0;
    arb_mode4  = 1'b0;
    out_ready4 = 1'b1;
    in_data3   = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    in_valid3  = 3'b000;
    sel3       = 2'd0;
    arb_mode3  = 1'b0;
    out_ready3 = 1'b1;

    // 1. Reset and idle.
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready4), 32'h0);
    check("rst_out_valid", 32'(out_valid4), 32'h0);
    check("rst_out_data", out_data4, 32'h0);
    check("rst_out_sel", 32'(out_sel4), 32'h0);
    pre();
    step_edge();
    step_edge();
    rst = 1'b1;
    pre();
    step_edge();
    check("rst_release_valid", 32'(out_valid4), 32'h1);

    // 2. Explicit select.
    sel4 = 2'd2;
    in_valid4 = 4'b0100;
    in_data4[64 +: 32] = 32'hCAFE_0002;
    pre();
    check("sel_in_ready", 32'(in_ready4), 32'h4);
    step_edge();
    check("sel_out_data", out_data4, 32'hCAFE_0002);
    check("sel_out_sel", 32'(out_sel4), 32'h2);
    in_valid4 = 4'b1011;
    pre();
    check("sel_novalid_ready", 32'(in_ready4), 32'h0);
    step_edge();
    check("sel_novalid_out_valid", 32'(out_valid4), 32'h0);

    // 3. Round-robin fairness; first load channel 3 so the pointer sits at 0.
    sel4 = 2'd3;
    in_valid4 = 4'b1000;
    pre();
    step_edge();
    arb_mode4 = 1'b1;
    in_valid4 = 4'b1111;
    exp_seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      pre();
      step_edge();
      check("rr_out_sel", 32'(out_sel4), 32'(exp_seq[i]));
      check("rr_out_valid", 32'(out_valid4), 32'h1);
    end

    // 4. Back-pressure: hold 32'h11 from channel 1 for three cycles.
    arb_mode4 = 1'b0;
    sel4 = 2'd1;
    in_valid4 = 4'b0010;
    in_data4[32 +: 32] = 32'h11;
    pre();
    step_edge();
    out_ready4 = 1'b0;
    arb_mode4 = 1'b1;
    in_valid4 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      pre();
      check("bp_in_ready", 32'(in_ready4), 32'h0);
      step_edge();
      check("bp_out_data", out_data4, 32'h11);
      check("bp_out_sel", 32'(out_sel4), 32'h1);
    end
    out_ready4 = 1'b1;
    pre();
    step_edge();
    check("bp_release_valid", 32'(out_valid4), 32'h1);
    check("bp_release_sel", 32'(out_sel4), 32'h2);

    // 5. Non-power-of-two wrap on the 3-channel instance.
    arb_mode3 = 1'b1;
    in_valid3 = 3'b101;
    exp3 = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      pre();
      step_edge();
      check("np2_out_sel", 32'(out_sel3), 32'(exp3[i]));
      check("np2_out_data", out_data3, in_data3[exp3[i]*32 +: 32]);
    end
    arb_mode3 = 1'b0;
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    #1;
    check("np2_sel3_ready", 32'(in_ready3), 32'h0);
    pre();
    step_edge();
    check("np2_sel3_valid", 32'(out_valid3), 32'h0);

    // 6. Reset mid-operation under back-pressure.
    arb_mode4 = 1'b1;
    in_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    pre();
    step_edge();
    out_ready4 = 1'b0;
    pre();
    step_edge();
    check("mid_hold_valid", 32'(out_valid4), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid4), 32'h0);
    check("mid_rst_data", out_data4, 32'h0);
    check("mid_rst_ready", 32'(in_ready4), 32'h0);
    model_reset();
    #1 rst = 1'b1;
    out_ready4 = 1'b1;
    pre();
    check("mid_restart_ready", 32'(in_ready4), 32'h1);
    step_edge();
    check("mid_restart_sel", 32'(out_sel4), 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid4  = 4'($urandom);
      in_data4   = {$urandom, $urandom, $urandom, $urandom};
      sel4       = 2'($urandom);
      arb_mode4  = 1'($urandom);
      out_ready4 = ($urandom_range(0, 3) != 0);
      pre();
      step_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_nway_reg.md
Name: mux_nway_reg

Overview:
- Registered N-input word multiplexer with per-input valid/ready handshake.
- Generalises the 2- and 3-input combinational select muxes to NUM_INPUTS channels.
- Two runtime modes: explicit select, or round-robin arbitration.
- Used where the pipeline merges several producers (e.g. writeback or forwarding sources) onto one registered stage with back-pressure.

Parameters:
- WORD_LENGTH, 32, data width per channel.
- NUM_INPUTS, 4, channel count; legal range 2..16, power of two not required.
- SEL_W (localparam), max(1, clog2(NUM_INPUTS)), width of select and index fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  NUM_INPUTS*WORD_LENGTH  flattened channel data; channel i occupies bits [i*WORD_LENGTH +: WORD_LENGTH].
- in_valid  input  NUM_INPUTS  per-channel valid.
- in_ready  output  NUM_INPUTS  per-channel ready; one-hot or zero; combinational.
- sel  input  SEL_W  channel index, used in mode 0 only.
- arb_mode  input  1  0 = explicit select; 1 = round-robin.
- out_data  output  WORD_LENGTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - While rst is low, in_ready=0.
  - Reset asserted mid-transfer discards the held word; no partial state survives.
- can_load = !out_valid || out_ready. This gives one register stage, full throughput of 1 word/cycle, and 1-cycle latency from input handshake to out_valid.
- Grant, mode 0:
  - grant_idx = sel; grant_vld = in_valid[sel].
  - sel >= NUM_INPUTS: grant_vld=0; no channel is ever readied.
- Grant, mode 1:
  - Scan indices ptr, ptr+1, ..., wrapping modulo NUM_INPUTS.
  - The first index with in_valid set is granted. grant_vld=0 if none is valid.
- in_ready[i] = rst && can_load && grant_vld && (grant_idx == i). All other bits are 0.
- Clock edge with can_load && grant_vld:
  - out_data <= channel grant_idx; out_sel <= grant_idx; out_valid <= 1.
  - ptr <= grant_idx+1, wrapping NUM_INPUTS-1 -> 0.
- Clock edge with can_load && !grant_vld: out_valid <= 0. out_data and out_sel hold their last values.
- Clock edge with !can_load (out_valid && !out_ready): out_data, out_sel, out_valid and ptr all hold.
  - Output stays stable under back-pressure.
- ptr advances only on a successful load, in both modes. Mode-0 transfers therefore also move ptr.
- arb_mode or sel changes take effect on the same cycle's combinational grant. No change ever affects a word already held.
- Simultaneous unload and load (out_valid && out_ready && grant_vld): the new word replaces the old one in the same edge, with no bubble.
- Inputs not readied must hold their data and valid; the block does not latch them.
- No X propagation: out_data derives only from the granted channel.

Test Plan:
1. Reset and idle: hold rst low, drive in_valid=4'b1111.
   - Required: in_ready=0, out_valid=0, out_data=0, out_sel=0.
   - After release with out_ready=1: out_valid=1 one cycle later.
2. Mode 0 select: sel=2, in_valid=4'b0100, channel 2 data=32'hCAFE0002, out_ready=1.
   - Required: in_ready=4'b0100; next cycle out_data=32'hCAFE0002, out_sel=2.
   - With sel=2 and in_valid=4'b1011: in_ready=0, and out_valid drops to 0.
3. Round-robin fairness: arb_mode=1, in_valid=4'b1111 held constant, out_ready=1.
   - Required: out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid held 1 throughout.
4. Back-pressure: out_valid=1 with out_data=32'h11, out_ready=0 for 3 cycles, other channels valid.
   - Required: in_ready=0 and out_data/out_sel unchanged for all 3 cycles.
   - On out_ready=1: the next word loads in the same edge, with no bubble.
5. Non-power-of-two wrap: NUM_INPUTS=3, arb_mode=1, in_valid=3'b101.
   - Required: out_sel sequence 0,2,0,2.
   - Mode 0 with sel=3: in_ready=0 and out_valid falls to 0.
6. Reset mid-operation: out_valid=1 under back-pressure, pulse rst low asynchronously between clock edges.
   - Required: out_valid=0 and out_data=0 immediately.
   - After release: arbitration restarts with ptr=0, so channel 0 is granted first when all channels are valid.
